// File: rtl/mac_sched_pkg.sv
// Shared types, widths and helpers for the MAC scheduler slice.
// The round-robin pick lives here so it can be reused by other arbiters.
package mac_sched_pkg;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned ACC_W  = 16;
   localparam int unsigned RR_MAX = 32;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain,
      StResult
   } state_t;

   function automatic int unsigned ID_W(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned LEN_W(input int unsigned m);
      return $clog2(m + 1);
   endfunction

   // First set bit of valid searching upward from ptr+1, wrapping at n.
   function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                          input logic [4:0]        ptr,
                                          input int unsigned       n);
      logic [5:0] idx;
      logic       found;
      rr_pick = '0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX; k++) begin
         idx = {1'b0, ptr} + 6'(k);
         if (idx >= 6'(n)) idx = idx - 6'(n);
         if (k <= n && !found && valid[idx[4:0]]) begin
            found   = 1'b1;
            rr_pick = idx[4:0];
         end
      end
   endfunction

endpackage

// File: rtl/mac_core.sv
// Two-stage signed MAC: stage 1 registers operands, stage 2 accumulates with
// sticky signed overflow. clr empties the pipeline and the accumulator.
module mac_core
   import mac_sched_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [OP_W-1:0]  a,
   input  logic signed [OP_W-1:0]  b,
   output logic signed [ACC_W-1:0] f,
   output logic                    overflow
);

   logic signed [OP_W-1:0]  a_q, b_q;
   logic                    v_q;
   logic signed [ACC_W-1:0] prod, sum;
   logic                    ovf_now;

   // Full-width product: -128 * -128 = 16384 still fits in 16 bits.
   always_comb begin
      prod    = ACC_W'(a_q) * ACC_W'(b_q);
      sum     = f + prod;
      ovf_now = (prod[ACC_W-1] == f[ACC_W-1]) && (sum[ACC_W-1] != f[ACC_W-1]);
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         a_q      <= '0;
         b_q      <= '0;
         v_q      <= 1'b0;
         f        <= '0;
         overflow <= 1'b0;
      end else begin
         v_q <= en;
         if (en) begin
            a_q <= a;
            b_q <= b;
         end
         if (v_q) begin
            f <= sum;
            if (ovf_now) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_scheduler.sv
// Round-robin scheduler sharing one MAC between N_REQ operand streams, one
// whole vector per grant, with a tagged valid/ready result port.
module mac_scheduler
   import mac_sched_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_REQ-1:0]                   req_valid,
   output logic [N_REQ-1:0]                   req_ready,
   input  logic [N_REQ-1:0][OP_W-1:0]         req_a,
   input  logic [N_REQ-1:0][OP_W-1:0]         req_b,
   input  logic [N_REQ-1:0]                   req_last,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic signed [ACC_W-1:0]            res_f,
   output logic                               res_overflow,
   output logic                               res_trunc,
   output logic [ID_W(N_REQ)-1:0]             res_id,
   output logic [LEN_W(MAX_LEN)-1:0]          res_len,
   output logic                               busy
);

   localparam int unsigned IdW  = ID_W(N_REQ);
   localparam int unsigned LenW = LEN_W(MAX_LEN);
   localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

   state_t              state;
   logic [IdW-1:0]      ptr;
   logic [4:0]          pick;
   logic [IdW-1:0]      grant;
   logic                hs;
   logic [LenW-1:0]     len_nxt;
   logic                mac_clr;
   logic signed [OP_W-1:0] a_sel, b_sel;

   always_comb begin
      pick    = rr_pick(RR_MAX'(req_valid), 5'(ptr), N_REQ);
      grant   = IdW'(pick);
      hs      = (state == StStream) && req_valid[res_id] && req_ready[res_id];
      len_nxt = res_len + LenW'(1);
      mac_clr = (state == StIdle);
      a_sel   = $signed(req_a[res_id]);
      b_sel   = $signed(req_b[res_id]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         ptr       <= IdW'(N_REQ - 1);
         res_id    <= '0;
         res_len   <= '0;
         res_trunc <= 1'b0;
         req_ready <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (|req_valid) begin
                  res_id    <= grant;
                  res_len   <= '0;
                  res_trunc <= 1'b0;
                  req_ready <= OneHot0 << grant;
                  busy      <= 1'b1;
                  state     <= StStream;
               end
            end
            StStream: begin
               if (hs) begin
                  res_len <= len_nxt;
                  // A MAX_LEN-th beat without last closes the vector; the rest
                  // of that stream re-arbitrates as a new vector.
                  if (req_last[res_id] || len_nxt == LenW'(MAX_LEN)) begin
                     res_trunc <= !req_last[res_id];
                     req_ready <= '0;
                     state     <= StDrain;
                  end
               end
            end
            StDrain: begin
               res_valid <= 1'b1;
               state     <= StResult;
            end
            StResult: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  ptr       <= res_id;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   mac_core u_mac_core (
      .clk      (clk),
      .reset    (reset),
      .clr      (mac_clr),
      .en       (hs),
      .a        (a_sel),
      .b        (b_sel),
      .f        (res_f),
      .overflow (res_overflow)
   );

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed scoreboard bench for mac_scheduler (N_REQ=4, MAX_LEN=4).
module tb_mac_scheduler;
   import mac_sched_pkg::*;

   localparam int unsigned N_REQ   = 4;
   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned IdW     = ID_W(N_REQ);
   localparam int unsigned LenW    = LEN_W(MAX_LEN);

   logic                       clk;
   logic                       reset;
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0][OP_W-1:0] req_a;
   logic [N_REQ-1:0][OP_W-1:0] req_b;
   logic [N_REQ-1:0]           req_last;
   logic                       res_valid;
   logic                       res_ready;
   logic signed [ACC_W-1:0]    res_f;
   logic                       res_overflow;
   logic                       res_trunc;
   logic [IdW-1:0]             res_id;
   logic [LenW-1:0]            res_len;
   logic                       busy;

   typedef struct {
      logic signed [ACC_W-1:0] f;
      logic                    ovf;
      logic                    trunc;
      logic [IdW-1:0]          id;
      logic [LenW-1:0]         len;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   mac_scheduler #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_last     (req_last),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_f        (res_f),
      .res_overflow (res_overflow),
      .res_trunc    (res_trunc),
      .res_id       (res_id),
      .res_len      (res_len),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_res(input int f, input bit ovf, input bit trunc,
                             input int id, input int len);
      exp_t x;
      x.f     = 16'(f);
      x.ovf   = ovf;
      x.trunc = trunc;
      x.id    = IdW'(id);
      x.len   = LenW'(len);
      exp_q.push_back(x);
   endtask

   // Present one beat on requester r and return just after it is accepted.
   task automatic beat(input int r, input int a, input int b, input bit last);
      int t = 0;
      req_valid[r] = 1'b1;
      req_a[r]     = 8'(a);
      req_b[r]     = 8'(b);
      req_last[r]  = last;
      @(negedge clk);
      while (!req_ready[r] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout req=%0d actual=no ready required=ready", r);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout actual pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_f"}, 32'(res_f), 32'd0);
      chk({tag, "_res_overflow"}, 32'(res_overflow), 32'd0);
      chk({tag, "_res_trunc"}, 32'(res_trunc), 32'd0);
      chk({tag, "_res_id"}, 32'(res_id), 32'd0);
      chk({tag, "_res_len"}, 32'(res_len), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Monitor: grant exclusivity every cycle, scoreboard pop on each result handshake.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL req_ready_onehot actual=%b required=at most one bit", req_ready);
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual id=%0d f=%0d required=none",
                        res_id, res_f);
            end else begin
               e = exp_q.pop_front();
               chk("res_f", 32'(res_f), 32'(e.f));
               chk("res_overflow", 32'(res_overflow), 32'(e.ovf));
               chk("res_trunc", 32'(res_trunc), 32'(e.trunc));
               chk("res_id", 32'(res_id), 32'(e.id));
               chk("res_len", 32'(res_len), 32'(e.len));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int hs;
      int t;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_last  = '0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Round-robin: req0 and req2 hold 1-beat vectors; ptr starts at 3.
      expect_res(16, 0, 0, 0, 1);
      expect_res(16, 0, 0, 2, 1);
      expect_res(16, 0, 0, 0, 1);
      expect_res(16, 0, 0, 2, 1);
      req_a[0] = 8'd4; req_b[0] = 8'd4; req_last[0] = 1'b1;
      req_a[2] = 8'd4; req_b[2] = 8'd4; req_last[2] = 1'b1;
      req_valid[0] = 1'b1;
      req_valid[2] = 1'b1;
      hs = 0;
      t  = 0;
      while (hs < 4 && t < 200) begin
         @(negedge clk);
         t++;
         if (req_ready[0] || req_ready[2]) hs++;
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last  = '0;
      wait_drain("round_robin");

      // Single vector from req1, result one cycle after the last handshake.
      expect_res(13, 0, 0, 1, 2);
      beat(1, 2, 2, 0);
      beat(1, 3, 3, 1);
      @(negedge clk);
      chk("drain_res_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("result_res_valid", 32'(res_valid), 32'd1);
      wait_drain("single");

      // Overflow: 3 * 16129 wraps to -17149; next vector starts clean.
      expect_res(-17149, 1, 0, 3, 3);
      expect_res(1, 0, 0, 3, 1);
      beat(3, 127, 127, 0);
      beat(3, 127, 127, 0);
      beat(3, 127, 127, 1);
      beat(3, 1, 1, 1);
      wait_drain("overflow");

      // Truncation at MAX_LEN=4; the fifth beat carries last to close its vector.
      expect_res(4, 0, 1, 0, 4);
      expect_res(1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) beat(0, 1, 1, 0);
      beat(0, 1, 1, 1);
      wait_drain("trunc");

      // Backpressure: three RESULT cycles refused, consumed on the fourth.
      res_ready = 1'b0;
      expect_res(30, 0, 0, 2, 1);
      beat(2, 5, 6, 1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_res_valid", 32'(res_valid), 32'd1);
         chk("bp_res_f", 32'(res_f), 32'd30);
         chk("bp_res_id", 32'(res_id), 32'd2);
         chk("bp_res_len", 32'(res_len), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_drain("backpressure");

      // Reset mid-STREAM after two beats; partial vector is dropped.
      beat(0, 7, 7, 0);
      beat(0, 7, 7, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk_all_zero("midreset");
      // ptr back at 3, so req0 beats req3 despite ptr having been 2.
      expect_res(6, 0, 0, 0, 1);
      expect_res(1, 0, 0, 3, 1);
      fork
         beat(0, 2, 3, 1);
         beat(3, 1, 1, 1);
      join
      wait_drain("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_scheduler.md
# mac_scheduler

Shares one signed 8×8→16 multiply-accumulate datapath between `N_REQ` requesters, one whole dot-product at a time. Each requester streams operand pairs with a `last` marker. The scheduler grants the MAC round-robin at vector boundaries, clears the accumulator per vector and returns one tagged result per vector on a valid/ready result port. It sits between the operand sources and the result consumer and owns the only MAC instance in the design.

## Interface
- `N_REQ`, 4: number of requesters (≥2)
- `MAX_LEN`, 16: maximum beats per vector; longer vectors are force-terminated
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_ready`  out  N_REQ  per-requester beat accept; at most one bit high
- `req_a`, `req_b`  in  N_REQ×8  signed operands per requester
- `req_last`  in  N_REQ  final beat of vector
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_f`  out  16  signed accumulated sum
- `res_overflow`  out  1  sticky signed overflow during this vector
- `res_trunc`  out  1  vector cut at MAX_LEN without `last`
- `res_id`  out  $clog2(N_REQ)  granted requester index
- `res_len`  out  $clog2(MAX_LEN+1)  beats accumulated
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, STREAM, DRAIN, RESULT.
- **IDLE**
  - All `req_ready` low; the MAC clear is asserted.
  - If any `req_valid` is high, grant the first valid index searching from `ptr+1` modulo N_REQ.
  - Latch the grant into `res_id` and go to STREAM; zero `res_len` and `res_trunc`.
- **STREAM**
  - `req_ready[g]` is high; all other bits are low.
  - A handshake (`req_valid[g] && req_ready[g]`) feeds `req_a[g]`, `req_b[g]` to the MAC and increments `res_len`.
  - Bubbles (valid low) are allowed; nothing is accumulated on those cycles.
  - A handshake with `req_last[g]` goes to DRAIN.
  - A handshake that brings `res_len` to MAX_LEN without `last` also goes to DRAIN and sets `res_trunc`. Following beats from that requester compete in the next arbitration round as a new vector.
- **DRAIN**: one cycle; no acceptance; the MAC commits the final product.
- **RESULT**
  - `res_valid` is high and all result fields are stable.
  - On `res_valid && res_ready`: set `ptr <= res_id` and go to IDLE.
- **Arithmetic**
  - Product is a full 16-bit signed value; −128×−128 = 16384 fits.
  - Accumulation wraps modulo 2^16.
  - Overflow is set when product and accumulator have equal sign bits and the sum's sign differs. It is sticky until the next clear.
- `reset` (any state, including mid-vector):
  - State goes to IDLE; `ptr` goes to N_REQ−1, so requester 0 wins first.
  - MAC pipeline is flushed; all outputs go to 0.
  - A partial vector is discarded and not reported.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_f`=0, `res_overflow`=0, `res_trunc`=0, `res_id`=0, `res_len`=0, `busy`=0.
- Grant overhead: one cycle in IDLE. `req_ready[g]` rises at the edge after `req_valid` is first seen in IDLE.
- MAC pipeline:
  - Stage 1 registers the operands on a handshake edge.
  - Stage 2 updates the accumulator on the next edge.
- Last beat accepted at edge T → DRAIN during T..T+1 → `res_valid` high from edge T+1. Sustained throughput is one beat per cycle.
- Minimum vector turnaround with `res_ready` tied high: length + 3 cycles (IDLE, beats, DRAIN, RESULT).
- `req_ready` and `res_valid` are registered state decodes. No combinational path exists from `res_ready` to `req_ready`.

## Structure
- Package `mac_sched_pkg` holds:
  - the `state_t` enum (IDLE, STREAM, DRAIN, RESULT);
  - the operand and accumulator width constants (8, 16);
  - the `ID_W`/`LEN_W` helper functions.
- Sub-module `mac_core` has ports `clk`, `reset`, `clr`, `en`, `a`, `b`, `f`, `overflow`. It is the 2-stage registered MAC with sticky overflow and is instantiated once.
- The round-robin pick is a function in the package.

## Test plan
- Single vector: req1 beats (2,2), (3,3, last) → `res_valid` one cycle after the last handshake; `res_f`=13, `res_len`=2, `res_id`=1, overflow=0.
- Round-robin: req0 and req2 each hold a 1-beat vector (4,4, last) continuously → result order is ids 0,2,0,2; `res_f`=16 each; `req_ready` is never high on two bits.
- Overflow: three beats (127,127), last on the third → `res_f`=−17149, `res_overflow`=1. The next vector (1,1, last) → `res_f`=1, overflow=0.
- Truncation (MAX_LEN=4): five beats of (1,1) with no `last` → first result has `res_len`=4, `res_trunc`=1, `res_f`=4. The fifth beat follows as a separate vector with `res_f`=1.
- Backpressure: hold `res_ready` low for 3 cycles in RESULT → fields stable, all `req_ready`=0, `busy`=1; the result is consumed on the 4th cycle.
- Reset mid-STREAM after 2 beats → next cycle all outputs are 0 and the state is IDLE. A following vector from req0 is granted first, with a fresh accumulator.
